tag_stream_arbiter: RTL and testbench
=====================================

Name: tag_stream_arbiter

Overview:
- Merges NUM_INPUTS AXI-Stream tag sources into one AXI-Stream output feeding the user tag-processing design.
- Sources are, for example, the live Time Tagger stream and replay or test-pattern generators.
- Arbitration is round-robin at packet granularity, so a granted packet is never interleaved with another and its tuser (wrap count) stays intact.
- Provides a forwarded-packet counter and grant status for the control plane.

Parameters:
- NUM_INPUTS, 2, number of slave streams; legal range 1..16, otherwise $error at elaboration.
- DATA_WIDTH, 32, tdata width per stream.
- KEEP_WIDTH, (DATA_WIDTH+7)/8, tkeep width per stream.
- USER_WIDTH, 32, tuser width per stream.
- WATCHDOG_CYCLES, 1024, stall limit used only when TAG_ARB_WATCHDOG_EN is defined; must be >= 2.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  NUM_INPUTS  per-source valid; bit i belongs to source i.
- s_axis_tready  out  NUM_INPUTS  per-source ready.
- s_axis_tdata  in  NUM_INPUTS*DATA_WIDTH  source i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tlast  in  NUM_INPUTS  per-source end of packet.
- s_axis_tkeep  in  NUM_INPUTS*KEEP_WIDTH  sliced like tdata.
- s_axis_tuser  in  NUM_INPUTS*USER_WIDTH  sliced like tdata.
- m_axis_tvalid  out  1  merged stream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_WIDTH  merged data.
- m_axis_tlast  out  1  merged end of packet.
- m_axis_tkeep  out  KEEP_WIDTH  merged keep.
- m_axis_tuser  out  USER_WIDTH  merged user.
- grant_valid  out  1  high while a source owns the output.
- grant_idx  out  4  index of the owning source; valid when grant_valid.
- pkt_count  out  32  count of packets completed on the master side.
- timeout_err  out  1  sticky watchdog flag; tied 0 without the macro.

Behaviour:
- Reset values: state IDLE, rr_ptr=0, grant_valid=0, grant_idx=0, pkt_count=0, timeout_err=0, all s_axis_tready=0, m_axis_tvalid=0. Reset wins over every other event.
- Reset mid-packet: the packet is abandoned immediately and no closing beat is emitted.
- States: IDLE, BUSY, and FLUSH (FLUSH exists only with the macro).
- IDLE:
  - No outputs active.
  - Search tvalid starting at rr_ptr, wrapping modulo NUM_INPUTS; the first set bit wins.
  - On a hit, register grant_idx=winner, set grant_valid=1, go to BUSY.
  - This costs exactly one bubble cycle per packet.
  - No hit: stay in IDLE.
- BUSY:
  - m_axis_* mirror source grant_idx combinationally, with zero latency.
  - s_axis_tready[grant_idx]=m_axis_tready; all other ready bits are 0.
  - Ungranted sources are never dropped, only stalled.
- Packet end: a beat with valid&ready&tlast on the master side does all of the following in the same cycle:
  - pkt_count++ (wraps 0xFFFFFFFF->0);
  - rr_ptr=(grant_idx+1) mod NUM_INPUTS;
  - grant_valid=0, next state IDLE.
- Single-beat packets are legal: one BUSY cycle, then IDLE.
- NUM_INPUTS=1: the same FSM applies, so one bubble per packet.
- tlast asserted without tvalid is ignored.
- tkeep and tuser pass through unaltered; there is no width or format conversion.

Optional Feature:
- Macro: TAG_ARB_WATCHDOG_EN.
- Defined:
  - In BUSY, a counter increments each cycle the granted source has tvalid=0 and resets on any granted tvalid=1.
  - The counter is not incremented when tvalid=1 and m_axis_tready=0, since downstream backpressure is not a source fault.
  - When the count reaches WATCHDOG_CYCLES: timeout_err<=1 (sticky until rst), s_axis_tready all 0, go to FLUSH.
  - FLUSH drives a single closing beat: m_axis_tvalid=1, tlast=1, tkeep=0, tdata=0, tuser=last forwarded tuser.
  - On handshake: pkt_count++, rr_ptr advances, go to IDLE.
  - The remainder of the abandoned packet from that source is accepted later as a new packet.
- Undefined: no counter, no FLUSH state, timeout_err tied 0, and a grant is held indefinitely.

Test Plan:
- Reset then idle: rst 2 cycles, no valid -> all readies 0, m_axis_tvalid 0, pkt_count 0, grant_valid 0.
- Round-robin fairness: NUM_INPUTS=2, both sources continuously offer 3-beat packets, m_axis_tready=1, 6 packets -> grant order 0,1,0,1,0,1; pkt_count=6; each packet's 3 beats contiguous; one bubble between packets; tuser per packet equals its source's value.
- No interleave under backpressure: source0 4-beat packet, m_axis_tready toggling 1010..., source1 valid throughout -> all 4 source0 beats exit before any source1 beat; s_axis_tready[1] stays 0 until source0's tlast handshakes.
- Skip idle sources: NUM_INPUTS=4, rr_ptr=1, only source3 valid -> grant_idx=3, then rr_ptr=0.
- Reset mid-packet: rst asserted after beat 2 of 5 -> next cycle state IDLE, tready 0, pkt_count 0; after release, source0 is granted first.
- Watchdog (macro defined, WATCHDOG_CYCLES=16): source0 sends 1 beat without tlast, then tvalid=0 -> after 16 stall cycles timeout_err=1, one beat with tlast=1, tkeep=0, pkt_count=1, then source1 granted; with the macro undefined the grant is still held at 1000 cycles.

Source files
------------

// File: rtl/tag_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tag_stream_arbiter
//
// Merges NUM_INPUTS AXI-Stream tag sources (live tagger stream, replay, test
// pattern generators) into one AXI-Stream output. Arbitration is round-robin
// at packet granularity: once a source is granted it owns the output until its
// tlast beat handshakes, so packets are never interleaved and tuser (the wrap
// count) stays attached to the right packet.
//
// Optional feature macro: TAG_ARB_WATCHDOG_EN
//   When defined, a granted source that stops offering data for
//   WATCHDOG_CYCLES consecutive cycles is cut off: a sticky timeout_err is
//   raised and a single empty closing beat (tlast=1, tkeep=0, tdata=0,
//   tuser=last forwarded tuser) is emitted so the downstream packet framing
//   stays intact. When undefined, timeout_err is tied low and a grant is
//   held for as long as the source takes.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   s_axis_*           NUM_INPUTS slave streams, source i in slice i
//   m_axis_*           merged master stream (zero-latency mux of the owner)
//   grant_valid        a source currently owns the output
//   grant_idx          index of the owning source
//   pkt_count          packets completed on the master side (wrapping)
//   timeout_err        sticky watchdog flag
// -----------------------------------------------------------------------------
module tag_stream_arbiter #(
  parameter int NUM_INPUTS      = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int KEEP_WIDTH      = (DATA_WIDTH + 7) / 8,
  parameter int USER_WIDTH      = 32,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS-1:0]            s_axis_tvalid,
  output logic [NUM_INPUTS-1:0]            s_axis_tready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_INPUTS-1:0]            s_axis_tlast,
  input  logic [NUM_INPUTS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_INPUTS*USER_WIDTH-1:0] s_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tlast,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  output logic                             grant_valid,
  output logic [3:0]                       grant_idx,
  output logic [31:0]                      pkt_count,
  output logic                             timeout_err
);

  // Elaboration-time parameter sanity checks.
  if (NUM_INPUTS < 1 || NUM_INPUTS > 16) begin : g_num_inputs_check
    $error("tag_stream_arbiter: NUM_INPUTS must be in 1..16");
  end
  if (WATCHDOG_CYCLES < 2) begin : g_watchdog_check
    $error("tag_stream_arbiter: WATCHDOG_CYCLES must be >= 2");
  end

  localparam logic [4:0] NUM_IN5 = 5'(NUM_INPUTS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1
`ifdef TAG_ARB_WATCHDOG_EN
    ,
    ST_FLUSH = 2'd2
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]  grant_idx_q, grant_idx_d;
  logic        grant_valid_q, grant_valid_d;
  logic [31:0] pkt_count_q, pkt_count_d;

`ifdef TAG_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [USER_WIDTH-1:0] last_tuser_q, last_tuser_d;
`endif

  logic                  search_hit;
  logic [3:0]            search_winner;
  logic [4:0]            cand;
  logic                  sel_valid, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic [USER_WIDTH-1:0] sel_user;
  logic                  busy, in_flush, m_hs;
  logic [3:0]            next_ptr;

  // Round-robin search: walk the sources starting at rr_ptr, wrapping
  // modulo NUM_INPUTS, and take the first one offering data. The candidate
  // index never needs more than one wrap since rr_ptr < NUM_INPUTS.
  always_comb begin
    search_hit    = 1'b0;
    search_winner = rr_ptr_q;
    cand          = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand = {1'b0, rr_ptr_q} + 5'(k);
      if (cand >= NUM_IN5) cand = cand - NUM_IN5;
      for (int j = 0; j < NUM_INPUTS; j++) begin
        if (!search_hit && cand == 5'(j) && s_axis_tvalid[j]) begin
          search_hit    = 1'b1;
          search_winner = 4'(j);
        end
      end
    end
  end

  // Select the granted source's stream signals. A one-hot compare loop keeps
  // the index width independent of NUM_INPUTS.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_idx_q == 4'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  // Output side. In BUSY the master mirrors the owner with zero latency and
  // only the owner sees m_axis_tready. Reset gates every handshake so a
  // packet in flight is dropped on the spot rather than closed.
  always_comb begin
    busy = (state_q == ST_BUSY);
`ifdef TAG_ARB_WATCHDOG_EN
    in_flush = (state_q == ST_FLUSH);
`else
    in_flush = 1'b0;
`endif
    m_axis_tvalid = ~rst & ((busy & sel_valid) | in_flush);
    m_axis_tdata  = busy ? sel_data : '0;
    m_axis_tlast  = busy ? sel_last : in_flush;
    m_axis_tkeep  = busy ? sel_keep : '0;
`ifdef TAG_ARB_WATCHDOG_EN
    m_axis_tuser  = busy ? sel_user : (in_flush ? last_tuser_q : '0);
`else
    m_axis_tuser  = busy ? sel_user : '0;
`endif
    s_axis_tready = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      s_axis_tready[i] = ~rst & busy & (grant_idx_q == 4'(i)) & m_axis_tready;
    end
  end

  assign m_hs     = m_axis_tvalid & m_axis_tready;
  assign next_ptr = (grant_idx_q == 4'(NUM_INPUTS - 1)) ? 4'd0 : grant_idx_q + 4'd1;

  // Next-state logic. A packet ends (normally or via the flush beat) by
  // bumping pkt_count, moving rr_ptr past the owner and dropping the grant,
  // which guarantees one idle bubble before the next grant.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    pkt_count_d   = pkt_count_q;
`ifdef TAG_ARB_WATCHDOG_EN
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
    last_tuser_d  = last_tuser_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (search_hit) begin
          grant_idx_d   = search_winner;
          grant_valid_d = 1'b1;
          state_d       = ST_BUSY;
`ifdef TAG_ARB_WATCHDOG_EN
          wd_cnt_d      = '0;
`endif
        end
      end
      ST_BUSY: begin
`ifdef TAG_ARB_WATCHDOG_EN
        if (m_hs) last_tuser_d = sel_user;
        // Only a silent source counts as a stall; backpressure does not.
        if (sel_valid) begin
          wd_cnt_d = '0;
        end else if (wd_cnt_q == WD_W'(WATCHDOG_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = ST_FLUSH;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`endif
        if (m_hs && sel_last) begin
          pkt_count_d   = pkt_count_q + 32'd1;
          rr_ptr_d      = next_ptr;
          grant_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
`ifdef TAG_ARB_WATCHDOG_EN
      ST_FLUSH: begin
        if (m_hs) begin
          pkt_count_d   = pkt_count_q + 32'd1;
          rr_ptr_d      = next_ptr;
          grant_valid_d = 1'b0;
          wd_cnt_d      = '0;
          state_d       = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      pkt_count_q   <= '0;
`ifdef TAG_ARB_WATCHDOG_EN
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
      last_tuser_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      pkt_count_q   <= pkt_count_d;
`ifdef TAG_ARB_WATCHDOG_EN
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
      last_tuser_q  <= last_tuser_d;
`endif
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign pkt_count   = pkt_count_q;
`ifdef TAG_ARB_WATCHDOG_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_tag_stream_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for tag_stream_arbiter (4 inputs, 16-cycle watchdog limit).
// Each source is a small packet generator whose beats carry
// {source, packet, beat} in tdata, so every merged beat identifies itself.
// Inputs change 1 time unit after posedge; a negedge monitor logs master
// handshakes and source handshakes for the generators.
// -----------------------------------------------------------------------------
module tb_tag_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 32;
  localparam int WD = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N*KW-1:0] s_axis_tkeep;
  logic [N*UW-1:0] s_axis_tuser;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          grant_valid, timeout_err;
  logic [3:0]    grant_idx;
  logic [31:0]   pkt_count;

  tag_stream_arbiter #(
    .NUM_INPUTS(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
    .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .grant_valid(grant_valid), .grant_idx(grant_idx),
    .pkt_count(pkt_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Packet generator state per source.
  int src_en[N]   = '{default: 0};
  int src_len[N]  = '{default: 1};
  int src_beat[N] = '{default: 0};
  int src_pkt[N]  = '{default: 0};
  int src_left[N] = '{default: 0};
  logic [N-1:0] s_hs = '0;

  // Log of master-side beats.
  logic [31:0] log_data[64];
  logic [31:0] log_user[64];
  logic [3:0]  log_keep[64];
  logic [3:0]  log_gidx[64];
  logic        log_last[64];
  int          log_cyc[64];
  int          log_n = 0;

  function automatic logic [31:0] expData(int i, int p, int b);
    return {i[7:0], p[7:0], b[15:0]};
  endfunction

  function automatic logic [31:0] expUser(int i, int p);
    return {16'hC0DE, i[7:0], p[7:0]};
  endfunction

  function automatic logic [3:0] expKeep(int i);
    return 4'hF >> i;
  endfunction

  // The single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive every source from its generator state. Idle sources hold tlast
  // high, which the arbiter has to ignore.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      s_axis_tvalid[i]             = (src_en[i] != 0);
      s_axis_tlast[i]              = (src_en[i] != 0) ? (src_beat[i] == src_len[i] - 1) : 1'b1;
      s_axis_tdata[i*DW +: DW]     = expData(i, src_pkt[i], src_beat[i]);
      s_axis_tkeep[i*KW +: KW]     = expKeep(i);
      s_axis_tuser[i*UW +: UW]     = expUser(i, src_pkt[i]);
    end
  endtask

  task automatic configSource(input int i, input int len, input int npkts);
    src_en[i]   = (npkts > 0) ? 1 : 0;
    src_len[i]  = len;
    src_beat[i] = 0;
    src_pkt[i]  = 0;
    src_left[i] = npkts;
  endtask

  // Monitor: sample the settled handshakes half a cycle before the edge.
  always @(negedge clk) begin
    cyc++;
    s_hs = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid && m_axis_tready && log_n < 64) begin
      log_data[log_n] = m_axis_tdata;
      log_user[log_n] = m_axis_tuser;
      log_keep[log_n] = m_axis_tkeep;
      log_gidx[log_n] = grant_idx;
      log_last[log_n] = m_axis_tlast;
      log_cyc[log_n]  = cyc;
      log_n++;
    end
  end

  // One clock: advance generators on handshakes, redrive, then settle.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (s_hs[i]) begin
        if (src_beat[i] == src_len[i] - 1) begin
          src_beat[i] = 0;
          src_pkt[i]++;
          src_left[i]--;
          if (src_left[i] == 0) src_en[i] = 0;
        end else begin
          src_beat[i]++;
        end
      end
    end
    applyStimulus();
    #2;
  endtask

  task automatic runUntil(input int nbeats, input int limit, input string tag);
    int c = 0;
    while (log_n < nbeats && c < limit) begin
      tick();
      c++;
    end
    checkOutput(tag, 32'(log_n), 32'(nbeats));
  endtask

  initial begin
    int early;
    logic [31:0] u0;

    // Reset then idle.
    rst = 1'b1;
    m_axis_tready = 1'b0;
    applyStimulus();
    repeat (2) tick();
    rst = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) tick();
    checkOutput("rst_tready", 32'(s_axis_tready), 32'h0);
    checkOutput("rst_mvalid", 32'(m_axis_tvalid), 32'h0);
    checkOutput("rst_pkt_count", pkt_count, 32'h0);
    checkOutput("rst_grant_valid", 32'(grant_valid), 32'h0);
    checkOutput("rst_grant_idx", 32'(grant_idx), 32'h0);
    checkOutput("rst_timeout", 32'(timeout_err), 32'h0);

    // Round-robin fairness: two sources, three 3-beat packets each.
    log_n = 0;
    configSource(0, 3, 3);
    configSource(1, 3, 3);
    applyStimulus();
    runUntil(18, 200, "rr_beats");
    for (int p = 0; p < 6; p++) begin
      for (int b = 0; b < 3; b++) begin
        int k;
        k = p * 3 + b;
        checkOutput("rr_data", log_data[k], expData(p % 2, p / 2, b));
        checkOutput("rr_last", 32'(log_last[k]), (b == 2) ? 32'd1 : 32'd0);
        checkOutput("rr_user", log_user[k], expUser(p % 2, p / 2));
        if (k > 0)
          checkOutput("rr_gap", 32'(log_cyc[k] - log_cyc[k-1]), (b == 0) ? 32'd2 : 32'd1);
      end
      checkOutput("rr_gidx", 32'(log_gidx[p*3]), 32'(p % 2));
      checkOutput("rr_keep", 32'(log_keep[p*3]), 32'(expKeep(p % 2)));
    end
    checkOutput("rr_pkt_count", pkt_count, 32'd6);

    // No interleave under toggling backpressure.
    log_n = 0;
    early = 0;
    configSource(0, 4, 1);
    configSource(1, 2, 1);
    applyStimulus();
    for (int c = 0; c < 200 && log_n < 6; c++) begin
      tick();
      if (s_axis_tready[1] && src_pkt[0] == 0) early++;
      m_axis_tready = ~m_axis_tready;
    end
    m_axis_tready = 1'b1;
    checkOutput("bp_beats", 32'(log_n), 32'd6);
    checkOutput("bp_early_ready1", 32'(early), 32'd0);
    for (int b = 0; b < 4; b++) begin
      checkOutput("bp_src0_data", log_data[b], expData(0, 0, b));
    end
    checkOutput("bp_src0_last", 32'(log_last[3]), 32'd1);
    checkOutput("bp_src1_first", log_data[4], expData(1, 0, 0));
    checkOutput("bp_src1_gidx", 32'(log_gidx[5]), 32'd1);
    checkOutput("bp_pkt_count", pkt_count, 32'd8);

    // Skip idle sources: a single-beat packet from 0 leaves rr_ptr at 1,
    // then only source 3 is offering.
    log_n = 0;
    configSource(0, 1, 1);
    applyStimulus();
    runUntil(1, 50, "skip_single_beat");
    checkOutput("skip_single_last", 32'(log_last[0]), 32'd1);
    configSource(3, 2, 1);
    applyStimulus();
    tick();
    checkOutput("skip_grant_valid", 32'(grant_valid), 32'd1);
    checkOutput("skip_grant_idx", 32'(grant_idx), 32'd3);
    runUntil(3, 50, "skip_src3_beats");
    configSource(0, 1, 1);
    configSource(1, 1, 1);
    configSource(2, 1, 1);
    applyStimulus();
    runUntil(6, 50, "skip_after_beats");
    checkOutput("skip_order0", 32'(log_gidx[3]), 32'd0);
    checkOutput("skip_order1", 32'(log_gidx[4]), 32'd1);
    checkOutput("skip_order2", 32'(log_gidx[5]), 32'd2);
    checkOutput("skip_pkt_count", pkt_count, 32'd13);

    // Reset in the middle of a 5-beat packet.
    log_n = 0;
    configSource(0, 5, 1);
    configSource(1, 1, 1);
    applyStimulus();
    runUntil(2, 50, "mid_two_beats");
    rst = 1'b1;
    tick();
    checkOutput("mid_grant_valid", 32'(grant_valid), 32'd0);
    checkOutput("mid_tready", 32'(s_axis_tready), 32'h0);
    checkOutput("mid_mvalid", 32'(m_axis_tvalid), 32'h0);
    checkOutput("mid_pkt_count", pkt_count, 32'd0);
    checkOutput("mid_no_close_beat", 32'(log_n), 32'd2);
    rst = 1'b0;
    tick();
    checkOutput("mid_regrant_valid", 32'(grant_valid), 32'd1);
    checkOutput("mid_regrant_idx", 32'(grant_idx), 32'd0);
    runUntil(6, 50, "mid_rest_beats");
    checkOutput("mid_rest_first", log_data[2], expData(0, 0, 2));
    checkOutput("mid_rest_last", 32'(log_last[4]), 32'd1);
    checkOutput("mid_src1_gidx", 32'(log_gidx[5]), 32'd1);
    checkOutput("mid_pkt_count_after", pkt_count, 32'd2);

    // Source 0 stalls after one beat while source 1 waits.
    log_n = 0;
    configSource(0, 4, 1);
    configSource(1, 1, 1);
    applyStimulus();
    u0 = expUser(0, 0);
    runUntil(1, 50, "wd_first_beat");
    src_en[0] = 0;
    applyStimulus();
`ifdef TAG_ARB_WATCHDOG_EN
    runUntil(3, 100, "wd_beats");
    checkOutput("wd_timeout", 32'(timeout_err), 32'd1);
    checkOutput("wd_stall_gap", 32'(log_cyc[1] - log_cyc[0]), 32'd17);
    checkOutput("wd_flush_last", 32'(log_last[1]), 32'd1);
    checkOutput("wd_flush_keep", 32'(log_keep[1]), 32'd0);
    checkOutput("wd_flush_data", log_data[1], 32'd0);
    checkOutput("wd_flush_user", log_user[1], u0);
    checkOutput("wd_next_gidx", 32'(log_gidx[2]), 32'd1);
    checkOutput("wd_pkt_count", pkt_count, 32'd4);
`else
    repeat (1000) tick();
    checkOutput("hold_grant_valid", 32'(grant_valid), 32'd1);
    checkOutput("hold_grant_idx", 32'(grant_idx), 32'd0);
    checkOutput("hold_beats", 32'(log_n), 32'd1);
    checkOutput("hold_tready1", 32'(s_axis_tready[1]), 32'd0);
    checkOutput("hold_timeout", 32'(timeout_err), 32'd0);
    checkOutput("hold_pkt_count", pkt_count, 32'd2);
    checkOutput("hold_first_user", log_user[0], u0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
